// File: rtl/stdp_pkg.sv
// Shared types and constants for the STDP weight loader: FSM states,
// error codes and weight-word geometry.
package stdp_pkg;

    localparam int W_BITS    = 4;
    localparam int N_PRE     = 4;
    localparam int WORD_BITS = W_BITS * N_PRE;

    localparam logic [1:0] ERR_CSUM    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HI     = 3'd1,
        LO     = 3'd2,
        CSUM   = 3'd3,
        COMMIT = 3'd4
    } state_e;

    function automatic logic [7:0] frame_csum(input logic [7:0] hi, input logic [7:0] lo);
        return hi ^ lo;
    endfunction

endpackage

// File: rtl/stdp_weight_loader_timeout_ctr.sv
// Inter-byte idle counter. expired fires in the cycle whose edge would
// take the count to TIMEOUT, so a byte arriving in that same cycle wins.
module timeout_ctr #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign expired = enable && !clear && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || expired) begin
            cnt_d = 8'd0;
        end else if (enable) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stdp_weight_loader.sv
// Byte-serial weight writer: parses HDR/D_HI/D_LO/CSUM frames and commits
// the 16-bit packed synapse weight word, holding STDP off mid-frame.
module stdp_weight_loader
    import stdp_pkg::*;
#(
    parameter logic [7:0]           HDR_BYTE     = 8'hA5,
    parameter int unsigned          TIMEOUT      = 255,
    parameter logic [WORD_BITS-1:0] RESET_WEIGHT = 16'h8888
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WORD_BITS-1:0] weight,
    output logic                 stdp_hold,
    output logic                 load_done,
    output logic                 load_err,
    output logic [1:0]           err_code,
    output logic [7:0]           drop_cnt
);

    state_e               state_q, state_d;
    logic [7:0]           shadow_hi_q, shadow_hi_d;
    logic [7:0]           shadow_lo_q, shadow_lo_d;
    logic [WORD_BITS-1:0] weight_q, weight_d;
    logic                 load_done_q, load_done_d;
    logic                 load_err_q, load_err_d;
    logic [1:0]           err_code_q, err_code_d;
    logic [7:0]           drop_cnt_q, drop_cnt_d;

    logic accept;
    logic in_frame;
    logic tmo_expired;

    assign in_ready  = !rst && (state_q != COMMIT);
    assign accept    = in_valid && in_ready;
    assign in_frame  = (state_q == HI) || (state_q == LO) || (state_q == CSUM);
    assign stdp_hold = (state_q != IDLE);

    timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept || !in_frame),
        .enable  (in_frame && !accept),
        .expired (tmo_expired)
    );

    // Weight and pulses are registered on the checksum edge so that they
    // are visible during the single COMMIT cycle.
    always_comb begin
        state_d     = state_q;
        shadow_hi_d = shadow_hi_q;
        shadow_lo_d = shadow_lo_q;
        weight_d    = weight_q;
        load_done_d = 1'b0;
        load_err_d  = 1'b0;
        err_code_d  = err_code_q;
        drop_cnt_d  = drop_cnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_data == HDR_BYTE) begin
                        state_d = HI;
                    end else if (drop_cnt_q != 8'hFF) begin
                        drop_cnt_d = drop_cnt_q + 8'd1;
                    end
                end
            end
            HI: begin
                if (accept) begin
                    shadow_hi_d = in_data;
                    state_d     = LO;
                end
            end
            LO: begin
                if (accept) begin
                    shadow_lo_d = in_data;
                    state_d     = CSUM;
                end
            end
            CSUM: begin
                if (accept) begin
                    state_d = COMMIT;
                    if (in_data == frame_csum(shadow_hi_q, shadow_lo_q)) begin
                        weight_d    = {shadow_hi_q, shadow_lo_q};
                        load_done_d = 1'b1;
                    end else begin
                        load_err_d = 1'b1;
                        err_code_d = ERR_CSUM;
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // tmo_expired is only ever set in HI/LO/CSUM with no byte accepted.
        if (tmo_expired) begin
            state_d    = IDLE;
            load_err_d = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shadow_hi_q <= 8'd0;
            shadow_lo_q <= 8'd0;
            weight_q    <= RESET_WEIGHT;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            err_code_q  <= 2'b00;
            drop_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            shadow_hi_q <= shadow_hi_d;
            shadow_lo_q <= shadow_lo_d;
            weight_q    <= weight_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
            err_code_q  <= err_code_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign weight    = weight_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;
    assign err_code  = err_code_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_stdp_weight_loader.sv
// Self-checking bench for stdp_weight_loader: directed frames, timeout,
// junk saturation, mid-frame reset and a short random frame mix.
module tb_stdp_weight_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] weight;
    logic        stdp_hold;
    logic        load_done;
    logic        load_err;
    logic [1:0]  err_code;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int hold_cnt = 0;
    logic mon_en = 1'b0;
    logic [15:0] cur_w;
    logic [17:0] exp_q[$];

    stdp_weight_loader #(
        .HDR_BYTE     (8'hA5),
        .TIMEOUT      (10),
        .RESET_WEIGHT (16'h8888)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .weight    (weight),
        .stdp_hold (stdp_hold),
        .load_done (load_done),
        .load_err  (load_err),
        .err_code  (err_code),
        .drop_cnt  (drop_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // driver tasks
    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        int   waited;
        rdy      = 1'b0;
        waited   = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!rdy && waited < 20) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        if (!rdy) check("send_stall", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] cs);
        if (cs == (hi ^ lo)) begin
            cur_w = {hi, lo};
            exp_q.push_back({2'b00, hi, lo});
        end else begin
            exp_q.push_back({2'b01, cur_w});
        end
        send_byte(8'hA5);
        send_byte(hi);
        send_byte(lo);
        send_byte(cs);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // scoreboard: every pulse pops one expected {code, weight} entry
    always @(negedge clk) begin
        if (stdp_hold) hold_cnt++;
        if (mon_en && (load_done || load_err)) begin
            check("pulse_excl", {31'd0, load_done & load_err}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, load_err, load_done}, 32'd0);
            end else begin
                check("commit_event", {14'd0, (load_err ? err_code : 2'b00), weight},
                      {14'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        logic [7:0] hi, lo, cs;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        cur_w    = 16'h8888;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_weight", {16'd0, weight}, 32'h8888);
        check("rst_flags", {28'd0, stdp_hold, load_done, load_err, 1'b0}, 32'd0);
        check("rst_err_code", {30'd0, err_code}, 32'd0);
        check("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // good frame, latency and hold window
        hold_cnt = 0;
        send_frame(8'h12, 8'h34, 8'h26);
        @(negedge clk);
        check("good_done", {31'd0, load_done}, 32'd1);
        check("good_weight", {16'd0, weight}, 32'h1234);
        check("commit_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("idle_done_low", {31'd0, load_done}, 32'd0);
        check("hold_cycles", hold_cnt, 32'd4);
        @(posedge clk);
        #1;

        // bad checksum
        send_frame(8'h12, 8'h34, 8'h00);
        @(negedge clk);
        check("csum_err", {31'd0, load_err}, 32'd1);
        check("csum_code", {30'd0, err_code}, 32'd1);
        check("csum_weight_kept", {16'd0, weight}, 32'h1234);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("csum_back_idle", {30'd0, stdp_hold, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // timeout after 10 idle cycles
        exp_q.push_back({2'b10, cur_w});
        send_byte(8'hA5);
        send_byte(8'h12);
        idle_cycles(9);
        @(negedge clk);
        check("tmo_not_yet", {30'd0, stdp_hold, load_err}, 32'd2);
        idle_cycles(1);
        @(negedge clk);
        check("tmo_err", {31'd0, load_err}, 32'd1);
        check("tmo_code", {30'd0, err_code}, 32'd2);
        check("tmo_idle", {31'd0, stdp_hold}, 32'd0);
        check("tmo_weight_kept", {16'd0, weight}, 32'h1234);
        @(posedge clk);
        #1;

        // byte on the 10th idle cycle wins
        exp_q.push_back({2'b00, 16'h5AC3});
        cur_w = 16'h5AC3;
        send_byte(8'hA5);
        send_byte(8'h5A);
        idle_cycles(9);
        send_byte(8'hC3);
        send_byte(8'h99);
        @(negedge clk);
        check("late_byte_done", {31'd0, load_done}, 32'd1);
        check("code_held", {30'd0, err_code}, 32'd2);
        @(posedge clk);
        #1;

        // junk bytes saturate drop_cnt
        check("drop_start", {24'd0, drop_cnt}, 32'd0);
        send_byte(8'h00);
        @(negedge clk);
        check("drop_one", {24'd0, drop_cnt}, 32'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 299; i++) send_byte(8'h00);
        @(negedge clk);
        check("drop_sat", {24'd0, drop_cnt}, 32'd255);
        check("junk_weight_kept", {16'd0, weight}, 32'h5AC3);
        @(posedge clk);
        #1;
        send_frame(8'h0F, 8'hF0, 8'hFF);
        idle_cycles(2);
        check("post_junk_weight", {16'd0, weight}, 32'h0FF0);

        // reset mid-frame
        send_byte(8'hA5);
        send_byte(8'hFF);
        rst = 1'b1;
        idle_cycles(1);
        @(negedge clk);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        check("midrst_weight", {16'd0, weight}, 32'h8888);
        check("midrst_hold", {31'd0, stdp_hold}, 32'd0);
        idle_cycles(1);
        rst   = 1'b0;
        cur_w = 16'h8888;
        check("midrst_drop_clr", {24'd0, drop_cnt}, 32'd0);
        send_frame(8'hAB, 8'hCD, 8'h66);
        idle_cycles(2);
        check("after_rst_weight", {16'd0, weight}, 32'hABCD);

        // random frame mix
        for (int i = 0; i < 8; i++) begin
            hi = 8'($urandom_range(0, 255));
            lo = 8'($urandom_range(0, 255));
            cs = hi ^ lo;
            if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
            send_frame(hi, lo, cs);
            idle_cycles($urandom_range(1, 4));
            check("rand_weight", {16'd0, weight}, {16'd0, cur_w});
        end

        idle_cycles(5);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/stdp_weight_loader.md
# stdp_weight_loader

Byte-serial weight writer for the STDP demo: receives framed weight-programming packets on an 8-bit input bus and drives the 16-bit packed synapse weight word (four 4-bit weights, pre1..pre4) that the STDP core and the weight readout pins consume. It is the write-side counterpart of the weight readout path. It validates each frame with a header and an XOR checksum, enforces an inter-byte timeout, and holds STDP learning off while a frame is in flight.

## Interface
Parameters:
- `HDR_BYTE`, 8'hA5, frame header value
- `TIMEOUT`, 255, max idle cycles between bytes inside a frame (1..255)
- `RESET_WEIGHT`, 16'h8888, weight word after reset (all four weights = 8)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_data`  in  8  frame byte
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  loader can accept a byte
- `weight`  out  16  packed weights: [15:12]=pre1, [11:8]=pre2, [7:4]=pre3, [3:0]=pre4
- `stdp_hold`  out  1  high while a frame is in progress; STDP updates suspended
- `load_done`  out  1  one-cycle pulse: new weight word committed
- `load_err`  out  1  one-cycle pulse: frame aborted
- `err_code`  out  2  cause, valid with `load_err`: 2'b01 checksum, 2'b10 timeout
- `drop_cnt`  out  8  count of non-header bytes discarded in IDLE, saturating at 255

## Operation
- Frame: `HDR_BYTE`, `D_HI` (weight[15:8]), `D_LO` (weight[7:0]), `CSUM` = `D_HI ^ D_LO`.
- Byte accepted on a cycle with `in_valid && in_ready`.
- States: IDLE, HI, LO, CSUM, COMMIT.
- IDLE: accepted byte == `HDR_BYTE` -> HI; any other byte is discarded, `drop_cnt` += 1 (saturating).
- HI: accepted byte latched as shadow high -> LO. LO: latched as shadow low -> CSUM.
- CSUM: accepted byte compared to shadow XOR -> COMMIT regardless of result.
- COMMIT (exactly one cycle): on match, `weight` <= shadow and `load_done` = 1; on mismatch, `weight` unchanged, `load_err` = 1, `err_code` = 01. Then -> IDLE.
- A header byte arriving in HI/LO/CSUM is treated as data, not a resync.
- Timeout counter (8 bits) clears on every accepted byte and on entry to HI; increments each cycle in HI/LO/CSUM without an accepted byte. On reaching `TIMEOUT`: -> IDLE, `load_err` = 1, `err_code` = 10, shadow discarded, `weight` unchanged.
- `stdp_hold` = 1 in HI, LO, CSUM, COMMIT; 0 in IDLE.
- `in_ready` = 1 in all states except COMMIT and while `rst` is high.

## Timing
- Reset values: `weight` = `RESET_WEIGHT`, `in_ready` = 0 during reset and 1 from the first cycle after, `stdp_hold` = 0, `load_done` = 0, `load_err` = 0, `err_code` = 0, `drop_cnt` = 0, state IDLE, timeout counter 0.
- All outputs are registered or decoded directly from state; no combinational path from `in_data`/`in_valid` to any output.
- Latency: checksum byte accepted at edge N. COMMIT is active in the cycle after N. `weight` and `load_done` (or `load_err`) are visible in that cycle. IDLE and `in_ready` = 1 in the following cycle.
- Minimum frame period is 5 cycles at continuous `in_valid`.
- `load_done` and `load_err` are mutually exclusive, single-cycle pulses. `err_code` holds its last value until the next `load_err`.
- Byte arriving in the same cycle the counter would hit `TIMEOUT`: the byte wins, and no timeout occurs.
- `rst` mid-frame: the frame is discarded, all reset values apply, and no `load_err` is issued.
- `in_valid` during COMMIT: the byte is not accepted and must be held by the sender.

## Structure
- Shared package `stdp_pkg`: state enum (IDLE/HI/LO/CSUM/COMMIT), `ERR_CSUM` = 2'b01, `ERR_TIMEOUT` = 2'b10, `W_BITS` = 4, `N_PRE` = 4, `WORD_BITS` = 16.
- One sub-module: `timeout_ctr` (clear, enable, `TIMEOUT` compare, expired flag). Everything else lives in the top FSM.

## Test plan
- Reset: assert `rst` 2 cycles -> `weight` = 16'h8888, `in_ready` = 0 during reset, 1 one cycle after release; all flags and `drop_cnt` = 0.
- Good frame A5,12,34,26 at continuous valid -> `load_done` pulses 1 cycle after the 26 is accepted, `weight` = 16'h1234, `stdp_hold` high for exactly 4 cycles.
- Bad checksum A5,12,34,00 -> `load_err` with `err_code` = 01, `weight` keeps its prior value, back in IDLE next cycle.
- Timeout: A5,12, then idle with `TIMEOUT` = 10 -> `load_err`/`err_code` = 10 after 10 idle cycles; byte on the 10th cycle instead -> frame continues.
- Junk: 300 bytes of 8'h00 in IDLE -> `drop_cnt` = 255 (saturated), `weight` unchanged; subsequent valid frame still commits.
- Reset mid-frame after A5,FF -> no pulse; `weight` = 16'h8888; new frame A5,AB,CD,66 commits 16'hABCD.
